// File: rtl/nn_argmax_stream.sv
// rtl/nn_argmax_stream.sv - streaming signed argmax over NUM_CLASSES logits with done pulse
// Optional second-best tracking and margin output: define NN_ARGMAX_MARGIN_EN.
`timescale 1ns/1ps
module nn_argmax_stream #(
    parameter int DATA_W      = 32,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     logit_valid,
    input  logic signed [DATA_W-1:0] logit_data,
    output logic                     logit_ready,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         argmax_out,
    output logic [DATA_W-1:0]        max_value,
    output logic [DATA_W:0]          margin
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] NO_RESULT = IDX_W'(10);

    state_t                    state, state_nx;
    logic                      start_q;
    logic                      start_rise;
    logic                      accept;
    logic [IDX_W-1:0]          cnt;
    logic signed [DATA_W-1:0]  best;
    logic [IDX_W-1:0]          best_idx;

    assign start_rise = start & ~start_q;
    assign accept     = logit_valid & logit_ready;

    always_comb begin
        state_nx    = state;
        logit_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise)
                    state_nx = COLLECT;
            end
            COLLECT: begin
                logit_ready = 1'b1;
                busy        = 1'b1;
                if (accept && cnt == LAST_BEAT)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge resetn) begin
        if (resetn) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            cnt        <= '0;
            best       <= '0;
            best_idx   <= '0;
            argmax_out <= NO_RESULT;
            max_value  <= '0;
        end else begin
            state   <= state_nx;
            start_q <= start;
            if (state == IDLE && start_rise)
                cnt <= '0;
            if (accept) begin
                cnt <= cnt + 1'b1;
                // Beat 0 loads unconditionally so an all-minimum frame still resolves to class 0.
                if (cnt == '0) begin
                    best     <= logit_data;
                    best_idx <= '0;
                end else if (logit_data > best) begin
                    best     <= logit_data;
                    best_idx <= cnt;
                end
            end
            if (state == DONE) begin
                argmax_out <= best_idx;
                max_value  <= best;
            end
        end
    end

`ifdef NN_ARGMAX_MARGIN_EN
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] second;

    always_ff @(posedge CLOCK_50 or posedge resetn) begin
        if (resetn) begin
            second <= '0;
            margin <= '0;
        end else begin
            if (accept) begin
                if (cnt == '0)
                    second <= MOST_NEG;
                else if (logit_data > best)
                    second <= best;
                else if (logit_data > second)
                    second <= logit_data;
            end
            if (state == DONE)
                margin <= {best[DATA_W-1], best} - {second[DATA_W-1], second};
        end
    end
`else
    assign margin = '0;
`endif

endmodule

// File: tb/tb_nn_argmax_stream.sv
// tb/tb_nn_argmax_stream.sv - directed and randomized bench for nn_argmax_stream
`timescale 1ns/1ps
module tb_nn_argmax_stream;

    localparam int DATA_W = 32;
    localparam int NUM    = 10;
    localparam int IDX_W  = 4;

    logic                     CLOCK_50 = 1'b0;
    logic                     resetn   = 1'b1;
    logic                     start    = 1'b0;
    logic                     logit_valid = 1'b0;
    logic signed [DATA_W-1:0] logit_data  = '0;
    logic                     logit_ready;
    logic                     busy;
    logic                     done;
    logic [IDX_W-1:0]         argmax_out;
    logic [DATA_W-1:0]        max_value;
    logic [DATA_W:0]          margin;

    int passes = 0;
    int total  = 0;

    logic signed [DATA_W-1:0] frame [NUM];

    nn_argmax_stream #(.DATA_W(DATA_W), .NUM_CLASSES(NUM), .IDX_W(IDX_W)) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .start      (start),
        .logit_valid(logit_valid),
        .logit_data (logit_data),
        .logit_ready(logit_ready),
        .busy       (busy),
        .done       (done),
        .argmax_out (argmax_out),
        .max_value  (max_value),
        .margin     (margin)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    // Reference: first index of the maximum; margin is max minus the largest of the remaining logits.
    function automatic void model(output int idx, output logic [DATA_W-1:0] mx, output logic [DATA_W:0] mg);
        longint b, s;
        idx = 0;
        b = longint'(frame[0]);
        for (int i = 1; i < NUM; i++)
            if (longint'(frame[i]) > b) begin
                b = longint'(frame[i]);
                idx = i;
            end
        s = -(64'sd1 <<< 62);
        for (int j = 0; j < NUM; j++)
            if (j != idx && longint'(frame[j]) > s)
                s = longint'(frame[j]);
        mx = DATA_W'(b);
        mg = (DATA_W+1)'(b - s);
    endfunction

    task automatic arm();
        start = 1'b0;
        @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic run_frame(input string tag, input bit toggle);
        int k, cyc, first, idx;
        logic [DATA_W-1:0] mx;
        logic [DATA_W:0]   mg;
        k = 0; cyc = 0; first = -1;
        while (k < NUM && cyc < 200) begin
            logit_valid = !toggle || (cyc % 2 == 0);
            logit_data  = frame[k];
            if (logit_valid && logit_ready) begin
                if (first < 0) first = cyc;
                k++;
            end
            @(negedge CLOCK_50);
            cyc++;
        end
        logit_valid = 1'b0;
        check({tag, "_beats"}, 64'(k), 64'(NUM));
        check({tag, "_done_pulse"}, 64'(done), 64'd1);
        check({tag, "_latency"}, 64'(cyc - first), toggle ? 64'd19 : 64'd10);
        @(negedge CLOCK_50);
        model(idx, mx, mg);
        check({tag, "_done_low"}, 64'(done), 64'd0);
        check({tag, "_argmax"}, 64'(argmax_out), 64'(idx));
        check({tag, "_max"}, 64'(max_value), 64'(mx));
`ifdef NN_ARGMAX_MARGIN_EN
        check({tag, "_margin"}, 64'(margin), 64'(mg));
`else
        check({tag, "_margin"}, 64'(margin), 64'd0);
`endif
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge CLOCK_50);
        check("rst_argmax", 64'(argmax_out), 64'd10);
        check("rst_done", 64'(done), 64'd0);
        check("rst_ready", 64'(logit_ready), 64'd0);
        check("rst_max", 64'(max_value), 64'd0);
        check("rst_margin", 64'(margin), 64'd0);
        resetn = 1'b0;
        @(negedge CLOCK_50);

        // Beats offered in IDLE are ignored
        logit_valid = 1'b1;
        logit_data  = 32'sd77;
        repeat (3) begin
            @(negedge CLOCK_50);
            check("idle_ready", 64'(logit_ready), 64'd0);
        end
        logit_valid = 1'b0;
        check("idle_argmax", 64'(argmax_out), 64'd10);

        // Reference frame, continuous then stalled every other cycle
        frame = '{32'sd5, -32'sd3, 32'sd12, 32'sd7, 32'sd0, 32'sd1, 32'sd2, 32'sd3, 32'sd4, -32'sd8};
        arm();
        run_frame("ref", 1'b0);
        check("ref_argmax_const", 64'(argmax_out), 64'd2);
        arm();
        run_frame("ref_toggle", 1'b1);

        // Ties keep the lower index
        frame = '{32'sd9, 32'sd9, 32'sd1, 32'sd1, 32'sd1, 32'sd1, 32'sd1, 32'sd1, 32'sd1, 32'sd1};
        arm();
        run_frame("tie", 1'b0);
        for (int i = 0; i < NUM; i++) frame[i] = 32'h8000_0000;
        arm();
        run_frame("all_min", 1'b0);
        check("all_min_max_const", 64'(max_value), 64'h8000_0000);

        // Start held high: no retrigger, outputs hold
        logit_valid = 1'b1;
        repeat (5) begin
            @(negedge CLOCK_50);
            check("held_ready", 64'(logit_ready), 64'd0);
        end
        logit_valid = 1'b0;
        check("held_argmax", 64'(argmax_out), 64'd0);
        for (int i = 0; i < NUM; i++) frame[i] = 32'sd0;
        frame[9] = 32'sd100;
        arm();
        check("hold_during_collect", 64'(argmax_out), 64'd0);
        run_frame("last_wins", 1'b0);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < NUM; i++) frame[i] = 32'sd50 - 32'(i);
        arm();
        for (int i = 0; i < 4; i++) begin
            logit_valid = 1'b1;
            logit_data  = frame[i];
            @(negedge CLOCK_50);
        end
        logit_valid = 1'b0;
        start  = 1'b0;
        resetn = 1'b1;
        #1;
        check("midrst_argmax", 64'(argmax_out), 64'd10);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_max", 64'(max_value), 64'd0);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        frame = '{-32'sd4, -32'sd9, 32'sd3, 32'sd8, -32'sd1, 32'sd8, 32'sd2, 32'sd0, 32'sd7, 32'sd6};
        arm();
        run_frame("post_rst", 1'b0);

        // Randomized frames; narrow ranges in some frames force ties
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NUM; i++)
                frame[i] = (f % 2 == 0) ? $signed($urandom) : 32'($urandom_range(6)) - 32'sd3;
            arm();
            run_frame($sformatf("rand%0d", f), f[1]);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nn_argmax_stream.md
Name: nn_argmax_stream

Overview:
- Streaming argmax stage between the output-layer MAC array and the digit display logic.
- Accepts NUM_CLASSES signed logits one per handshake and finds the index of the largest.
- Presents the index as a 4-bit class code, where 10 means "no result", with a one-cycle done pulse.
- Its argmax_out/done drive the seven-segment decoder and the top-level FSM debug LEDs.

Parameters:
- DATA_W, 32, logit width, two's-complement signed
- NUM_CLASSES, 10, logits per frame; legal range 2..15
- IDX_W, 4, width of index and beat counter

Ports:
- CLOCK_50  in  1  system clock, 50 MHz, rising edge
- resetn  in  1  asynchronous, active-high reset
- start  in  1  level from switch; its rising edge arms a new frame
- logit_valid  in  1  upstream beat valid
- logit_data  in  DATA_W  signed logit; beat k is class k
- logit_ready  out  1  block accepts a beat this cycle
- busy  out  1  high in COLLECT
- done  out  1  one-cycle pulse when argmax_out updates
- argmax_out  out  IDX_W  winning class index; 10 = none
- max_value  out  DATA_W  logit of the winning class
- margin  out  DATA_W+1  best minus second-best, unsigned; see Optional Feature

Behaviour:
- Reset values, applied asynchronously while resetn=1:
  - state=IDLE, logit_ready=0, busy=0, done=0
  - argmax_out=4'd10, max_value=0, margin=0
  - beat counter=0, start edge register=0
- Start detection: start is registered once. start_rise = start & ~start_q. start_rise is evaluated only in IDLE; a rise in COLLECT or DONE is ignored.
- IDLE:
  - logit_ready=0, busy=0.
  - On start_rise: go to COLLECT, clear counter, clear the first-beat flag.
- COLLECT:
  - logit_ready=1 combinationally, busy=1.
  - A beat is accepted when logit_valid & logit_ready. Cycles with valid=0 are stalls; state holds.
  - Beat 0 loads best=logit_data and best_idx=0 unconditionally. This handles all logits equal to the most negative value.
  - Beat k>0: if logit_data > best (signed, strict), then best=logit_data and best_idx=k.
  - Ties keep the lower index.
  - After the beat with counter==NUM_CLASSES-1 is accepted, go to DONE. No further beat is accepted in that cycle.
- DONE (exactly one cycle):
  - argmax_out<=best_idx, max_value<=best, done=1.
  - Next state IDLE.
  - Latency: done is high on the cycle after the last accepted beat.
- Hold rule: argmax_out and max_value keep their previous frame's values during a new COLLECT. They change only in DONE or on reset.
- Back-to-back frames: start must fall and rise again. Holding start high does not retrigger.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values, so argmax_out=10.
- Counter is IDX_W bits and never wraps: the terminal compare is NUM_CLASSES-1.

Optional Feature:
- Macro: NN_ARGMAX_MARGIN_EN.
- Defined:
  - Track second-best in parallel with best.
  - On beat 0: second=most-negative DATA_W value.
  - On a new best: second=old best.
  - Else, if logit_data > second: second=logit_data.
  - In DONE: margin<=best-second, computed sign-extended to DATA_W+1; result is non-negative.
- Undefined: second-best logic is omitted and margin is tied to 0.
- Port list is identical in both cases.

Test Plan:
- Reset with resetn=1, then release → argmax_out=10, done=0, logit_ready=0. Beats offered in IDLE are not accepted.
- Start rise, then 10 consecutive beats {5,-3,12,7,0,1,2,3,4,-8} → done pulses once on the cycle after beat 9; argmax_out=2, max_value=12. With the macro, margin=5.
- Same frame with logit_valid toggled 1/0 every cycle → identical result; done occurs 19 cycles after the first beat.
- Tie frame {9,9,1,...,1} → argmax_out=0. All-equal frame of 0x80000000 → argmax_out=0, max_value=0x80000000.
- Start held high after a frame, beats offered → not accepted, argmax_out holds. Start toggle 0→1 → new frame {0,...,0,100 at index 9} gives argmax_out=9.
- resetn pulsed after 4 beats of a frame → argmax_out=10 and state IDLE immediately. A later full frame computes correctly from beat 0.
